// File: rtl/blit_pkg.sv
// Shared constants, widths and FSM state type for the sprite blitter.
// Framebuffer geometry and transparent colour key live here.
package blit_pkg;
  localparam int unsigned H_RES  = 640;
  localparam int unsigned V_RES  = 361;
  localparam int          PIX_W  = 12;
  localparam int          FB_AW  = 19;
  localparam int          ROM_AW = 12;
  localparam logic [PIX_W-1:0] KEY_DEFAULT = 12'hF0F;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } blit_state_e;
endpackage

// File: rtl/fb_addr_gen.sv
// Framebuffer address and clip flag from a destination pixel.
// Ports: i_dx/i_dy in (11b), o_addr out (19b), o_clip out.
module fb_addr_gen
  import blit_pkg::*;
(
  input  logic [10:0]      i_dx,
  input  logic [10:0]      i_dy,
  output logic [FB_AW-1:0] o_addr,
  output logic             o_clip
);
  localparam logic [10:0] HL = 11'(H_RES);
  localparam logic [10:0] VL = 11'(V_RES);

  logic [19:0] w_dy20;
  logic [19:0] w_sum;

  // dy*640 = dy*512 + dy*128
  assign w_dy20 = {9'd0, i_dy};
  assign w_sum  = (w_dy20 << 9) + (w_dy20 << 7)
                + {9'd0, i_dx};

  // bit 19 can only be set for rows far past V_RES,
  // so folding it into clip changes nothing
  assign o_clip = (i_dx >= HL) | (i_dy >= VL)
                | w_sum[19];
  assign o_addr = w_sum[FB_AW-1:0];
endmodule

// File: rtl/fb_sprite_writer.sv
// Blits a sprite from ROM into the RGB framebuffer with key/clip.
// Ports: start/busy/done handshake, rom_addr/rom_data, fb_we/addr/din.
module fb_sprite_writer
  import blit_pkg::*;
#(
  parameter logic [PIX_W-1:0] KEY = KEY_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [9:0]        x0,
  input  logic [9:0]        y0,
  input  logic [6:0]        spr_w,
  input  logic [6:0]        spr_h,
  input  logic [ROM_AW-1:0] spr_base,
  input  logic              wr_ok,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [PIX_W-1:0]  fb_din,
  output logic              busy,
  output logic              done
);
  blit_state_e       r_state;
  logic [9:0]        r_x0;
  logic [9:0]        r_y0;
  logic [6:0]        r_w;
  logic [6:0]        r_h;
  logic [6:0]        r_col;
  logic [6:0]        r_row;
  logic [ROM_AW-1:0] r_rom;
  logic              r_sv;
  logic              r_clip;
  logic [FB_AW-1:0]  r_addr;
  logic              r_busy;
  logic              r_done;

  logic              w_issue;
  logic              w_last_col;
  logic              w_last;
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic [FB_AW-1:0]  w_addr;
  logic              w_clip;

  assign w_issue    = (r_state == RUN) & wr_ok;
  assign w_last_col = (r_col == (r_w - 7'd1));
  assign w_last     = w_last_col
                    & (r_row == (r_h - 7'd1));
  assign w_dx       = {1'b0, r_x0} + {4'd0, r_col};
  assign w_dy       = {1'b0, r_y0} + {4'd0, r_row};

  fb_addr_gen u_addr_gen (
    .i_dx   (w_dx),
    .i_dy   (w_dy),
    .o_addr (w_addr),
    .o_clip (w_clip)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_rom   <= '0;
      r_sv    <= 1'b0;
      r_clip  <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // write stage: one pixel in flight at most
      r_sv <= w_issue;
      if (w_issue) begin
        r_addr <= w_addr;
        r_clip <= w_clip;
        r_rom  <= r_rom + 12'd1;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_x0  <= x0;
            r_y0  <= y0;
            r_w   <= spr_w;
            r_h   <= spr_h;
            r_col <= '0;
            r_row <= '0;
            r_rom <= spr_base;
            if (spr_w == 7'd0 || spr_h == 7'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wr_ok) begin
            if (w_last) begin
              r_state <= DRAIN;
            end else if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 7'd1;
            end else begin
              r_col <= r_col + 7'd1;
            end
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_addr = r_rom;
  assign fb_we    = r_sv & ~r_clip & (rom_data != KEY);
  assign fb_addr  = r_addr;
  // held at zero while nothing is in flight
  assign fb_din   = r_sv ? rom_data : '0;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule

// File: doc/fb_sprite_writer.md
# fb_sprite_writer

Writes a rectangular sprite from the sprite ROM into the 12-bit RGB framebuffer RAM. The VGA scan path reads that framebuffer to drive pixels; this block is the write side of the same memory, in the same pixel format. Sprite pixels equal to the transparency key are skipped, and pixels outside the visible field are clipped. Software-side logic starts a blit with a start/busy/done handshake, and writes proceed only while `wr_ok` (typically vertical blanking) is high.

## Interface
- `H_RES`, 640, framebuffer width in pixels (row stride).
- `V_RES`, 361, framebuffer height in rows.
- `KEY`, 12'hF0F, transparent colour; magenta in {blue[11:8], green[7:4], red[3:0]} packing.
- `clk`  in  1  system clock; single clock domain.
- `clr`  in  1  synchronous active-high reset.
- `start`  in  1  request a blit; sampled only in IDLE.
- `x0`, `y0`  in  10 each  destination top-left pixel.
- `spr_w`, `spr_h`  in  7 each  sprite size, 0..64.
- `spr_base`  in  12  ROM word address of the sprite's first pixel; sprite is stored row-major and contiguous.
- `wr_ok`  in  1  write window open; a pixel issues only in a cycle where this is high.
- `rom_addr`  out  12  sprite ROM address.
- `rom_data`  in  12  ROM read data, valid one cycle after `rom_addr`.
- `fb_we`  out  1  framebuffer write enable.
- `fb_addr`  out  19  framebuffer address, y*H_RES + x.
- `fb_din`  out  12  framebuffer write data.
- `busy`  out  1  blit in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Operands are latched at start acceptance: x0, y0, spr_w, spr_h, spr_base. Later changes to these inputs have no effect on the running blit.
- FSM states are IDLE, RUN, DRAIN and DONE.
- **IDLE**
  - start=1 with spr_w≠0 and spr_h≠0: go to RUN.
  - start=1 with spr_w=0 or spr_h=0: go directly to DONE; no writes occur.
- **RUN**
  - Each cycle with wr_ok=1 issues one pixel (row, col):
    - rom_addr is driven from a running 12-bit counter. It starts at spr_base, increments by 1 per issued pixel, and wraps modulo 4096.
    - A pipeline stage captures dx=x0+col, dy=y0+row (11-bit, no overflow), the computed address, and a clip flag (dx≥H_RES or dy≥V_RES).
  - col advances 0..spr_w-1. When col wraps, row advances.
  - After the last pixel (spr_h-1, spr_w-1) issues, go to DRAIN.
  - A cycle with wr_ok=0 issues nothing; counters hold.
- **DRAIN**: one cycle; completes the final pipeline write. Next state is DONE.
- **DONE**: one cycle with done=1. Next state is IDLE.
- **Write stage**: fb_we = stage_valid & ~clip & (rom_data≠KEY); fb_addr = stage address; fb_din = rom_data.
  - An issued pixel is written in the following cycle regardless of that cycle's wr_ok.
- busy=1 in RUN and DRAIN. done=1 only in DONE.
- start while not in IDLE is ignored and not queued.
- Address arithmetic: dy*640 is formed as (dy<<9)+(dy<<7), then dx is added. Width is 20 bits internally; only unclipped values are used, and those always fit in 19 bits.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_din=0, rom_addr=0, busy=0, done=0, state IDLE, stage_valid=0.
- clr mid-blit: at the next edge, state returns to IDLE and stage_valid clears. fb_we=0 from that cycle on, and no done pulse is produced.
- Start accepted at edge 0, with wr_ok held at 1:
  - pixel k issues in cycle 1+k;
  - it is written in cycle 2+k;
  - DRAIN is cycle W·H+1;
  - done is in cycle W·H+2.
- Each cycle of wr_ok=0 during RUN delays every later event by exactly one cycle.
- Zero-size blit: done occurs in cycle 1 and busy never rises.
- Throughput is one pixel per clock. Latency from rom_addr to fb_we is one clock.

## Structure
- Shared package `blit_pkg`: H_RES, V_RES, KEY default, the FSM state enum (IDLE, RUN, DRAIN, DONE), and pixel/address width constants (12, 19).
- One sub-module: `fb_addr_gen`. It is combinational; it takes dx, dy and produces a 19-bit address plus the clip flag, using shift-add with no multiplier.

## Test plan
- **Basic 2x2 blit**: 2x2 at (10,5), spr_base=0, ROM[0..3]=111,222,333,444, wr_ok=1 → writes {3210:111, 3211:222, 3850:333, 3851:444} in cycles 2..5; done in cycle 6.
- **Transparency**: same as above with ROM[1]=F0F → only 3210, 3850 and 3851 are written; done timing is unchanged (cycle 6).
- **Clipping**: 2x2 at (639,360) → only address 231039 is written; no other fb_we; done in cycle 6.
- **Stall**: wr_ok forced low for 3 cycles after the second issue → the same 4 writes occur in the same order; done in cycle 9.
- **Handshake edges**:
  - start pulsed while busy → ignored; exactly one done pulse.
  - spr_w=0 → done in cycle 1 with zero writes.
  - rom_addr wraps from 4095 to 0 when spr_base=4094 and the sprite is 2x2.
- **Reset mid-run**: clr asserted in cycle 3 of a 4x4 blit → busy=0 and fb_we=0 from the next cycle; no done pulse; a fresh blit after reset completes normally.
